// File: rtl/adc_sim_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adc_sim_arbiter_pkg
//   Shared types for the adc_sim sample-source arbiters.
//   - state_t   : arbiter FSM encoding (S_IDLE .. S_RELEASE)
//   - rr_pick_t : result of a round-robin search (valid + index)
//   - rr_pick() : first set request bit at/after a pointer, wrapping at num_ch.
//                 Works on a fixed-width (RR_MAX_CH) request vector so that
//                 arbiters of any size up to RR_MAX_CH can reuse it.
// -----------------------------------------------------------------------------
package adc_sim_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_FULFILL = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int unsigned RR_MAX_CH  = 16;
  localparam int unsigned RR_IDX_WID = 4;

  typedef struct packed {
    logic                  valid;
    logic [RR_IDX_WID-1:0] idx;
  } rr_pick_t;

  // Scans offsets from the largest down to zero so the last hit written is
  // the one closest to (at or after) ptr.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0]  req,
                                       input logic [RR_IDX_WID-1:0] ptr,
                                       input int                    num_ch);
    rr_pick_t r;
    int       p;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int k = RR_MAX_CH - 1; k >= 0; k--) begin
      if (k < num_ch) begin
        p = int'(ptr) + k;
        if (p >= num_ch) p = p - num_ch;
        if (req[p]) begin
          r.valid = 1'b1;
          r.idx   = p[RR_IDX_WID-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_sim_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin first-set-bit finder.
//   Ports:
//     req   in  NUM_CH  pending request vector
//     ptr   in  CH_WID  search start index (highest priority this round)
//     grant out CH_WID  index of the chosen request (0 when none)
//     valid out 1       at least one request pending
// -----------------------------------------------------------------------------
module rr_priority_pick
  import adc_sim_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_WID = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_WID-1:0] ptr,
  output logic [CH_WID-1:0] grant,
  output logic              valid
);

  logic [RR_MAX_CH-1:0] req_ext;
  rr_pick_t             pick;

  // NOTE: every signal written in always_comb is given a default first so no
  // path leaves it unassigned; an unassigned path infers a latch.
  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req;
    pick                = rr_pick(req_ext, RR_IDX_WID'(ptr), NUM_CH);
    grant               = pick.idx[CH_WID-1:0];
    valid               = pick.valid;
  end

endmodule

// File: rtl/adc_sim_arbiter.sv
// -----------------------------------------------------------------------------
// adc_sim_arbiter
//   Shares one host-side sample source among NUM_CH simulated ADCs.
//   A round-robin pick selects a requesting channel, one WID-bit sample is
//   fetched from the host, then presented on the shared ch_indat bus together
//   with that channel's fulfilled strobe until the channel drops its request.
//
//   Ports:
//     clk           in   1       system clock
//     rst_L         in   1       asynchronous active-low reset
//     ch_request    in   NUM_CH  per-channel sample request from adc_sim
//     ch_fulfilled  out  NUM_CH  per-channel fulfilled strobe (one-hot or 0)
//     ch_indat      out  WID     shared sample bus to all adc_sim instances
//     host_req      out  1       sample wanted for host_ch
//     host_ch       out  CH_WID  channel of the outstanding fetch
//     host_ack      in   1       host sample valid (pulse or level)
//     host_dat      in   WID     host sample, taken when host_ack=1
//     busy          out  1       FSM not idle
//     timeout       out  1       sticky: host failed to ack in time
//     served_cnt    out  16      wrapping count of completed grants
//
//   All strobes are decoded straight from registered state, so an async reset
//   drops them in the same cycle.
// -----------------------------------------------------------------------------
module adc_sim_arbiter
  import adc_sim_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_WID  = 2,
  parameter int WID     = 18,
  parameter int TMO_WID = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic [NUM_CH-1:0] ch_request,
  output logic [NUM_CH-1:0] ch_fulfilled,
  output logic [WID-1:0]    ch_indat,
  output logic              host_req,
  output logic [CH_WID-1:0] host_ch,
  input  logic              host_ack,
  input  logic [WID-1:0]    host_dat,
  output logic              busy,
  output logic              timeout,
  output logic [15:0]       served_cnt
);

  localparam logic [CH_WID-1:0] LAST_CH = CH_WID'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [CH_WID-1:0]   cur_ch_q;
  logic [CH_WID-1:0]   rr_ptr_q;
  logic [WID-1:0]      data_q;
  logic [TMO_WID-1:0]  tmo_cnt_q;
  logic                timeout_q;
  logic [15:0]         served_q;

  logic [CH_WID-1:0]   pick_ch;
  logic                pick_valid;
  logic                cur_req;
  logic                tmo_expired;

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .CH_WID (CH_WID)
  ) u_pick (
    .req   (ch_request),
    .ptr   (rr_ptr_q),
    .grant (pick_ch),
    .valid (pick_valid)
  );

  assign cur_req     = ch_request[cur_ch_q];
  assign tmo_expired = &tmo_cnt_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    host_req     = 1'b0;
    ch_fulfilled = '0;
    busy         = (state_q != S_IDLE);
    host_ch      = cur_ch_q;
    ch_indat     = data_q;
    timeout      = timeout_q;
    served_cnt   = served_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) state_d = S_FETCH;
      end
      S_FETCH: begin
        host_req = 1'b1;
        // An ack beats a simultaneous request drop: the sample is already
        // here, so deliver it rather than discard it.
        if (host_ack)         state_d = S_FULFILL;
        else if (!cur_req)    state_d = S_IDLE;
        else if (tmo_expired) state_d = S_FULFILL;
      end
      S_FULFILL: begin
        ch_fulfilled = NUM_CH'(1) << cur_ch_q;
        if (!cur_req) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: grant latch, timeout counter, sample register, rr pointer, count
  // ---------------------------------------------------------------------------
  // NOTE: the sample and counters are reset too, because the outputs they
  // drive must read as zero after reset, not as power-up garbage.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cur_ch_q  <= '0;
      rr_ptr_q  <= '0;
      data_q    <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      served_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            cur_ch_q  <= pick_ch;
            tmo_cnt_q <= '0;
          end
        end
        S_FETCH: begin
          if (host_ack) begin
            data_q <= host_dat;
          end else if (cur_req) begin
            if (tmo_expired) begin
              // Deliver a zero sample so the waiting ADC cannot hang.
              timeout_q <= 1'b1;
              data_q    <= '0;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_WID'(1);
            end
          end
        end
        S_RELEASE: begin
          rr_ptr_q <= (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_WID'(1);
          served_q <= served_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_fulfilled_onehot0 : assert property (@(posedge clk) disable iff (!rst_L)
    $onehot0(ch_fulfilled));
  a_rr_ptr_range : assert property (@(posedge clk) disable iff (!rst_L)
    rr_ptr_q <= LAST_CH);

endmodule

// File: tb/tb_adc_sim_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adc_sim_arbiter
//   Directed bench: drives ch_request as the adc_sim channels would and models
//   the host with a programmable ack delay (or no ack at all).
// -----------------------------------------------------------------------------
module tb_adc_sim_arbiter;

  localparam int NUM_CH  = 4;
  localparam int CH_WID  = 2;
  localparam int WID     = 18;
  localparam int TMO_WID = 4;

  logic              clk = 1'b0;
  logic              rst_L;
  logic [NUM_CH-1:0] ch_request;
  logic [NUM_CH-1:0] ch_fulfilled;
  logic [WID-1:0]    ch_indat;
  logic              host_req;
  logic [CH_WID-1:0] host_ch;
  logic              host_ack;
  logic [WID-1:0]    host_dat;
  logic              busy;
  logic              timeout;
  logic [15:0]       served_cnt;

  logic              auto_ack;
  logic              force_ack;
  logic [WID-1:0]    host_sample;
  bit                host_en;
  int                host_delay;

  int n_checks;
  int n_fail;

  assign host_ack = auto_ack | force_ack;
  assign host_dat = host_sample;

  always #5 clk = ~clk;

  adc_sim_arbiter #(
    .NUM_CH  (NUM_CH),
    .CH_WID  (CH_WID),
    .WID     (WID),
    .TMO_WID (TMO_WID)
  ) dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .ch_request   (ch_request),
    .ch_fulfilled (ch_fulfilled),
    .ch_indat     (ch_indat),
    .host_req     (host_req),
    .host_ch      (host_ch),
    .host_ack     (host_ack),
    .host_dat     (host_dat),
    .busy         (busy),
    .timeout      (timeout),
    .served_cnt   (served_cnt)
  );

  // Host model: acks host_delay negedges after it first sees host_req.
  initial begin
    int wait_cnt;
    auto_ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (host_req && host_en && !auto_ack) begin
        if (wait_cnt >= host_delay) begin
          auto_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        auto_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_L      = 1'b0;
    ch_request = '0;
    force_ack  = 1'b0;
    host_en    = 1'b1;
    host_delay = 0;
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for any fulfilled strobe; returns at that negedge.
  task automatic wait_fulfill(input int max_cyc, output bit seen, output int ch,
                              output logic [WID-1:0] dat);
    seen = 1'b0;
    ch   = -1;
    dat  = '0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (ch_fulfilled != '0) begin
        seen = 1'b1;
        dat  = ch_indat;
        for (int c = 0; c < NUM_CH; c++) if (ch_fulfilled[c]) ch = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_L      = 1'b0;
    ch_request = '0;
    force_ack  = 1'b0;
    host_en    = 1'b1;
    host_delay = 0;
    host_sample = '0;
    @(negedge clk);
    n_checks++;
    if ({ch_fulfilled, ch_indat, host_req, host_ch, busy, timeout, served_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: fulfilled=%b indat=%h host_req=%b host_ch=%0d busy=%b timeout=%b served=%0d, expected all 0",
               ch_fulfilled, ch_indat, host_req, host_ch, busy, timeout, served_cnt);
    end
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit seen; int ch; logic [WID-1:0] dat;
    apply_reset();
    host_delay  = 3;
    host_sample = 18'h2A5A5;
    ch_request  = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (host_req !== 1'b1 || host_ch !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_fetch: host_req=%b host_ch=%0d busy=%b, expected 1/1/1", host_req, host_ch, busy);
    end
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 1 || dat !== 18'h2A5A5) begin
      n_fail++;
      $display("FAIL single_grant: seen=%b ch=%0d dat=%h, expected ch 1 dat 2a5a5", seen, ch, dat);
    end
    n_checks++;
    if (host_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_host_req_drop: host_req=%b, expected 0", host_req);
    end
    ch_request = '0;
    @(negedge clk);
    n_checks++;
    if (ch_fulfilled !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: fulfilled=%b busy=%b, expected 0000/1", ch_fulfilled, busy);
    end
    @(negedge clk);
    n_checks++;
    if (served_cnt !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count: served=%0d busy=%b, expected 1/0", served_cnt, busy);
    end
    // rr_ptr is now 2: ch2 must beat ch0.
    host_delay  = 0;
    host_sample = 18'h01234;
    ch_request  = 4'b0101;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 2 || dat !== 18'h01234) begin
      n_fail++;
      $display("FAIL single_rr_ptr: seen=%b ch=%0d dat=%h, expected ch 2 dat 01234", seen, ch, dat);
    end
    ch_request[2] = 1'b0;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 0) begin
      n_fail++;
      $display("FAIL single_rr_next: seen=%b ch=%0d, expected ch 0", seen, ch);
    end
    ch_request = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (served_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL single_count3: served=%0d, expected 3", served_cnt);
    end
  endtask

  task automatic test_fairness();
    bit seen; int ch; logic [WID-1:0] dat;
    int served[NUM_CH];
    apply_reset();
    for (int c = 0; c < NUM_CH; c++) served[c] = 0;
    host_delay = 1;
    ch_request = 4'hF;
    for (int k = 0; k < 32; k++) begin
      host_sample = 18'h10000 + WID'(k);
      wait_fulfill(40, seen, ch, dat);
      n_checks++;
      if (!seen || ch !== (k % NUM_CH) || dat !== 18'h10000 + WID'(k)) begin
        n_fail++;
        $display("FAIL fair_grant_%0d: seen=%b ch=%0d dat=%h, expected ch %0d dat %h",
                 k, seen, ch, dat, k % NUM_CH, 18'h10000 + WID'(k));
      end
      if (ch >= 0) begin
        served[ch]++;
        ch_request[ch] = 1'b0;
        @(negedge clk);
        if (served[ch] < 8) ch_request[ch] = 1'b1;
      end
    end
    ch_request = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (served_cnt !== 16'd32 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_count: served=%0d busy=%b, expected 32/0", served_cnt, busy);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (served[c] != 8) begin
        n_fail++;
        $display("FAIL fair_per_ch%0d: served %0d times, expected 8", c, served[c]);
      end
    end
  endtask

  task automatic test_abort();
    bit seen; int ch; logic [WID-1:0] dat;
    int pulses;
    apply_reset();
    host_en    = 1'b0;
    ch_request = 4'b0100;
    repeat (5) @(negedge clk);
    n_checks++;
    if (host_req !== 1'b1 || host_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_fetch: host_req=%b host_ch=%0d, expected 1/2", host_req, host_ch);
    end
    ch_request = '0;
    @(negedge clk);
    n_checks++;
    if (host_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: host_req=%b busy=%b, expected 0/0", host_req, busy);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ch_fulfilled != '0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || served_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_no_grant: fulfilled pulses=%0d served=%0d, expected 0/0", pulses, served_cnt);
    end
    // rr_ptr must still be 0: ch0 beats ch3.
    host_en     = 1'b1;
    host_delay  = 0;
    host_sample = 18'h00ABC;
    ch_request  = 4'b1001;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 0 || dat !== 18'h00ABC) begin
      n_fail++;
      $display("FAIL abort_ptr_kept: seen=%b ch=%0d dat=%h, expected ch 0 dat 00abc", seen, ch, dat);
    end
    ch_request[0] = 1'b0;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 3) begin
      n_fail++;
      $display("FAIL abort_next: seen=%b ch=%0d, expected ch 3", seen, ch);
    end
    ch_request = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen; int ch; logic [WID-1:0] dat;
    apply_reset();
    host_en     = 1'b0;
    host_sample = 18'h3FFFF;
    ch_request  = 4'b0001;
    repeat (10) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0 || host_req !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early: timeout=%b host_req=%b, expected 0/1", timeout, host_req);
    end
    wait_fulfill(30, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 0 || dat !== 18'h00000 || timeout !== 1'b1 || host_req !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: seen=%b ch=%0d dat=%h timeout=%b host_req=%b, expected ch 0 dat 00000 timeout 1 host_req 0",
               seen, ch, dat, timeout, host_req);
    end
    ch_request = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || served_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL tmo_idle: busy=%b served=%0d, expected 0/1", busy, served_cnt);
    end
    host_en     = 1'b1;
    host_delay  = 2;
    host_sample = 18'h15555;
    ch_request  = 4'b0010;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 1 || dat !== 18'h15555 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_recover: seen=%b ch=%0d dat=%h timeout=%b, expected ch 1 dat 15555 timeout 1",
               seen, ch, dat, timeout);
    end
    ch_request = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    apply_reset();
    host_en    = 1'b0;
    ch_request = 4'b1000;
    repeat (4) @(negedge clk);
    n_checks++;
    if (host_req !== 1'b1 || host_ch !== 2'd3) begin
      n_fail++;
      $display("FAIL tie_fetch: host_req=%b host_ch=%0d, expected 1/3", host_req, host_ch);
    end
    host_sample = 18'h3C3C3;
    force_ack   = 1'b1;
    ch_request  = '0;
    @(negedge clk);
    force_ack = 1'b0;
    n_checks++;
    if (ch_fulfilled !== 4'b1000 || ch_indat !== 18'h3C3C3) begin
      n_fail++;
      $display("FAIL tie_fulfill: fulfilled=%b indat=%h, expected 1000/3c3c3", ch_fulfilled, ch_indat);
    end
    @(negedge clk);
    n_checks++;
    if (ch_fulfilled !== '0 || busy !== 1'b1 || ch_indat !== 18'h3C3C3) begin
      n_fail++;
      $display("FAIL tie_release: fulfilled=%b busy=%b indat=%h, expected 0000/1/3c3c3", ch_fulfilled, busy, ch_indat);
    end
    @(negedge clk);
    n_checks++;
    if (served_cnt !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_count: served=%0d busy=%b, expected 1/0", served_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int ch; logic [WID-1:0] dat;
    apply_reset();
    host_delay  = 0;
    host_sample = 18'h0F0F0;
    ch_request  = 4'b0010;
    wait_fulfill(40, seen, ch, dat);
    ch_request = '0;
    repeat (2) @(negedge clk);
    host_en    = 1'b0;
    ch_request = 4'b0100;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 2 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: seen=%b ch=%0d timeout=%b, expected ch 2 timeout 1", seen, ch, timeout);
    end
    rst_L = 1'b0;
    #1;
    n_checks++;
    if (ch_fulfilled !== '0 || host_req !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || served_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: fulfilled=%b host_req=%b busy=%b timeout=%b served=%0d, expected all 0",
               ch_fulfilled, host_req, busy, timeout, served_cnt);
    end
    ch_request = '0;
    @(negedge clk);
    rst_L       = 1'b1;
    host_en     = 1'b1;
    host_sample = 18'h2BEEF;
    ch_request  = 4'b0101;
    wait_fulfill(40, seen, ch, dat);
    n_checks++;
    if (!seen || ch !== 0 || dat !== 18'h2BEEF) begin
      n_fail++;
      $display("FAIL rstmid_ptr: seen=%b ch=%0d dat=%h, expected ch 0 dat 2beef", seen, ch, dat);
    end
    ch_request = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_timeout();
    test_tie();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
